// File: rtl/mixer_pkg.sv
// Shared mixer types, Q-format constants and width/saturation helpers.
// Pure declarations, no timing; nothing here applies backpressure.
package mixer_pkg;

    localparam int DEF_BITSIZE = 16;
    localparam int SHIFT       = DEF_BITSIZE - 2;
    localparam int GAIN_ONE    = 2 ** SHIFT;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_t;

    function automatic int acc_width(input int bitsize, input int nch);
        return bitsize + 2 + $clog2(nch);
    endfunction

    function automatic int q_shift(input int bitsize);
        return bitsize - 2;
    endfunction

    // Clamp a sign-extended value into the signed range of 'width' bits.
    function automatic logic signed [63:0] sat_to(input logic signed [63:0] v, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/mixer_sat.sv
// Combinational clamp or wrap from IN_W to OUT_W bits plus out-of-range flag.
// Zero latency; no flow control.
module mixer_sat
    import mixer_pkg::*;
#(
    parameter int IN_W     = 20,
    parameter int OUT_W    = 16,
    parameter int SATURATE = 1
) (
    input  logic signed [IN_W-1:0]  acc,
    output logic signed [OUT_W-1:0] y,
    output logic                    clip
);

    logic signed [63:0] acc_w;
    logic signed [63:0] sat_w;

    always_comb begin
        acc_w = 64'(acc);
        sat_w = sat_to(acc_w, OUT_W);
        clip  = (sat_w != acc_w);
        y     = (SATURATE != 0) ? sat_w[OUT_W-1:0] : acc[OUT_W-1:0];
    end

endmodule

// File: rtl/mixer_n.sv
// N-channel weighted mixer, one MAC per bclk; out_valid NCH+1 cycles after frame start.
// No backpressure: a new frame start aborts any frame in progress and sets sticky overrun.
module mixer_n
    import mixer_pkg::*;
#(
    parameter int BITSIZE  = 16,
    parameter int NCH      = 4,
    parameter int SATURATE = 1
) (
    input  logic                       bclk,
    input  logic                       reset,
    input  logic                       lrclk,
    input  logic [NCH*BITSIZE-1:0]     in_bus,
    input  logic [NCH*BITSIZE-1:0]     gain_bus,
    input  logic [NCH-1:0]             mute,
    output logic signed [BITSIZE-1:0]  out,
    output logic                       out_valid,
    output logic                       clip,
    output logic                       busy,
    output logic                       overrun
);

    localparam int ACC_W  = acc_width(BITSIZE, NCH);
    localparam int SHF    = q_shift(BITSIZE);
    localparam int PROD_W = 2 * BITSIZE;
    localparam int WIDE_W = (PROD_W > ACC_W) ? PROD_W : ACC_W;
    localparam int IDX_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

    state_t                     state_q, state_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic                       lrclk_d_q, lrclk_d_d;
    logic signed [BITSIZE-1:0]  in_s_q [NCH];
    logic signed [BITSIZE-1:0]  in_s_d [NCH];
    logic signed [BITSIZE-1:0]  gain_s_q [NCH];
    logic signed [BITSIZE-1:0]  gain_s_d [NCH];
    logic [NCH-1:0]             mute_s_q, mute_s_d;
    logic signed [BITSIZE-1:0]  out_q, out_d;
    logic                       out_valid_q, out_valid_d;
    logic                       clip_q, clip_d;
    logic                       busy_q, busy_d;
    logic                       overrun_q, overrun_d;

    logic                       frame_start;
    logic signed [BITSIZE-1:0]  cur_in;
    logic signed [BITSIZE-1:0]  cur_gain;
    logic signed [PROD_W-1:0]   prod;
    logic signed [WIDE_W-1:0]   prod_sh;
    logic signed [ACC_W-1:0]    term;
    logic signed [BITSIZE-1:0]  sat_y;
    logic                       sat_clip;

    mixer_sat #(
        .IN_W     (ACC_W),
        .OUT_W    (BITSIZE),
        .SATURATE (SATURATE)
    ) u_sat (
        .acc  (acc_q),
        .y    (sat_y),
        .clip (sat_clip)
    );

    // Full-width signed product, arithmetic shift floors the Q1 gain scaling.
    always_comb begin
        cur_in   = in_s_q[idx_q];
        cur_gain = gain_s_q[idx_q];
        prod     = cur_in * cur_gain;
        prod_sh  = WIDE_W'(prod) >>> SHF;
        term     = mute_s_q[idx_q] ? '0 : ACC_W'(prod_sh);
    end

    assign frame_start = lrclk & ~lrclk_d_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        lrclk_d_d   = lrclk;
        in_s_d      = in_s_q;
        gain_s_d    = gain_s_q;
        mute_s_d    = mute_s_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        clip_d      = clip_q;
        busy_d      = busy_q;
        overrun_d   = overrun_q;

        if (frame_start) begin
            if (state_q != IDLE)
                overrun_d = 1'b1;
            state_d  = MAC;
            acc_d    = '0;
            idx_d    = '0;
            busy_d   = 1'b1;
            mute_s_d = mute;
            for (int k = 0; k < NCH; k++) begin
                in_s_d[k]   = in_bus[k*BITSIZE +: BITSIZE];
                gain_s_d[k] = gain_bus[k*BITSIZE +: BITSIZE];
            end
        end else begin
            case (state_q)
                MAC: begin
                    acc_d = acc_q + term;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    out_d       = sat_y;
                    clip_d      = sat_clip;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge bclk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            lrclk_d_q   <= 1'b0;
            in_s_q      <= '{default: '0};
            gain_s_q    <= '{default: '0};
            mute_s_q    <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            clip_q      <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            lrclk_d_q   <= lrclk_d_d;
            in_s_q      <= in_s_d;
            gain_s_q    <= gain_s_d;
            mute_s_q    <= mute_s_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            clip_q      <= clip_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign clip      = clip_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_mixer_n.sv
// Scoreboard bench for mixer_n: saturating N=4, wrapping N=4 and saturating N=8 instances.
module tb_mixer_n;
    import mixer_pkg::*;

    localparam int G = GAIN_ONE;

    logic bclk = 1'b0;
    always #5 bclk = ~bclk;

    int cyc = 0;
    always @(posedge bclk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        int out;
        int clip;
        int cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_w[$];
    exp_t q_8[$];

    logic               rst, rst_8;
    logic               lrclk_a, lrclk_w, lrclk_8;
    logic [63:0]        in_a, gain_a, in_w, gain_w;
    logic [127:0]       in_8, gain_8;
    logic [3:0]         mute_a, mute_w;
    logic [7:0]         mute_8;
    logic signed [15:0] out_a, out_w, out_8;
    logic               ov_a, ov_w, ov_8;
    logic               clip_a, clip_w, clip_8;
    logic               busy_a, busy_w, busy_8;
    logic               ovr_a, ovr_w, ovr_8;

    mixer_n #(.BITSIZE(16), .NCH(4), .SATURATE(1)) u_a (
        .bclk(bclk), .reset(rst), .lrclk(lrclk_a), .in_bus(in_a), .gain_bus(gain_a),
        .mute(mute_a), .out(out_a), .out_valid(ov_a), .clip(clip_a), .busy(busy_a),
        .overrun(ovr_a));

    mixer_n #(.BITSIZE(16), .NCH(4), .SATURATE(0)) u_w (
        .bclk(bclk), .reset(rst), .lrclk(lrclk_w), .in_bus(in_w), .gain_bus(gain_w),
        .mute(mute_w), .out(out_w), .out_valid(ov_w), .clip(clip_w), .busy(busy_w),
        .overrun(ovr_w));

    mixer_n #(.BITSIZE(16), .NCH(8), .SATURATE(1)) u_8 (
        .bclk(bclk), .reset(rst_8), .lrclk(lrclk_8), .in_bus(in_8), .gain_bus(gain_8),
        .mute(mute_8), .out(out_8), .out_valid(ov_8), .clip(clip_8), .busy(busy_8),
        .overrun(ovr_8));

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    // Monitors: every out_valid pulse must match the oldest expected frame, including its cycle.
    always @(negedge bclk) begin
        if (ov_a) begin
            if (q_a.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL a_extra_valid: out_valid with no frame pending, out=%0d", out_a);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                chk("a_out", int'(out_a), e.out);
                chk("a_clip", int'(clip_a), e.clip);
                chk("a_latency", cyc, e.cyc);
            end
        end
    end

    always @(negedge bclk) begin
        if (ov_w) begin
            if (q_w.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL w_extra_valid: out_valid with no frame pending, out=%0d", out_w);
            end else begin
                exp_t e;
                e = q_w.pop_front();
                chk("w_out", int'(out_w), e.out);
                chk("w_clip", int'(clip_w), e.clip);
                chk("w_latency", cyc, e.cyc);
            end
        end
    end

    always @(negedge bclk) begin
        if (ov_8) begin
            if (q_8.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL n8_extra_valid: out_valid with no frame pending, out=%0d", out_8);
            end else begin
                exp_t e;
                e = q_8.pop_front();
                chk("n8_out", int'(out_8), e.out);
                chk("n8_clip", int'(clip_8), e.clip);
                chk("n8_latency", cyc, e.cyc);
            end
        end
    end

    // Called on a negedge: the following posedge is t0, out_valid is seen NCH+2 counts later.
    task automatic frame_a(input int eo, input int ec, input int gap);
        lrclk_a = 1'b1;
        q_a.push_back('{eo, ec, cyc + 6});
        @(negedge bclk);
        lrclk_a = 1'b0;
        repeat (gap) @(negedge bclk);
    endtask

    task automatic frame_w(input int eo, input int ec);
        lrclk_w = 1'b1;
        q_w.push_back('{eo, ec, cyc + 6});
        @(negedge bclk);
        lrclk_w = 1'b0;
        repeat (10) @(negedge bclk);
    endtask

    initial begin
        rst = 1'b1; rst_8 = 1'b1;
        lrclk_a = 1'b0; lrclk_w = 1'b0; lrclk_8 = 1'b0;
        in_a = '0; gain_a = '0; mute_a = '0;
        in_w = '0; gain_w = '0; mute_w = '0;
        in_8 = '0; gain_8 = '0; mute_8 = '0;
        repeat (3) @(negedge bclk);

        chk("rst_out", int'(out_a), 0);
        chk("rst_valid", int'(ov_a), 0);
        chk("rst_clip", int'(clip_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_overrun", int'(ovr_a), 0);
        chk("rst_w_busy_ovr_clip", int'({busy_w, ovr_w, clip_w}), 0);
        chk("rst_n8_state", int'({ov_8, busy_8, ovr_8, clip_8}), 0);
        rst = 1'b0; rst_8 = 1'b0;
        repeat (2) @(negedge bclk);

        // Unity sum with busy window.
        in_a = pack4(1000, 2000, -500, 1500); gain_a = pack4(G, G, G, G); mute_a = 4'b0000;
        frame_a(4000, 0, 0);
        chk("a_busy_first", int'(busy_a), 1);
        repeat (4) @(negedge bclk);
        chk("a_busy_last", int'(busy_a), 1);
        @(negedge bclk);
        chk("a_busy_end", int'(busy_a), 0);
        repeat (5) @(negedge bclk);

        // Floor rounding of a half-gain negative, muted channel 1.
        in_a = pack4(-3, 100, 0, 0); gain_a = pack4(G / 2, G, G, G); mute_a = 4'b0010;
        frame_a(-2, 0, 30);
        chk("a_hold_out", int'(out_a), -2);
        chk("a_hold_valid", int'(ov_a), 0);

        // Snapshot: inputs change mid-frame, next frame uses the new values.
        in_a = pack4(10, 20, 30, 40); gain_a = pack4(G, G, G, G); mute_a = 4'b0000;
        frame_a(100, 0, 1);
        in_a = pack4(1, 2, 3, 4); gain_a = pack4(G / 2, G / 2, G / 2, G / 2);
        repeat (8) @(negedge bclk);
        frame_a(4, 0, 10);

        // Saturation and range boundaries.
        gain_a = pack4(G, G, G, G);
        in_a = pack4(32767, 32767, 32767, 32767);   frame_a(32767, 1, 10);
        in_a = pack4(-32768, -32768, -32768, -32768); frame_a(-32768, 1, 10);
        in_a = pack4(32767, 0, 0, 0);               frame_a(32767, 0, 10);
        in_a = pack4(-32768, 0, 0, 0);              frame_a(-32768, 0, 10);
        in_a = pack4(32767, 1, 0, 0);               frame_a(32767, 1, 10);
        chk("a_no_overrun", int'(ovr_a), 0);

        // Wrapping instance.
        gain_w = pack4(G, G, G, G);
        in_w = pack4(32767, 32767, 32767, 32767); frame_w(-4, 1);
        in_w = pack4(1000, 2000, -500, 1500);     frame_w(4000, 0);
        in_w = pack4(32767, 1, 0, 0);             frame_w(-32768, 1);

        // NCH=8 normal frame with top channel muted.
        for (int k = 0; k < 8; k++) begin
            in_8[k*16 +: 16]   = 16'((k + 1) * 100);
            gain_8[k*16 +: 16] = 16'(G);
        end
        mute_8 = 8'h80;
        lrclk_8 = 1'b1;
        q_8.push_back('{2800, 0, cyc + 10});
        @(negedge bclk); lrclk_8 = 1'b0;
        repeat (14) @(negedge bclk);

        // Restart at t0+4: only the restarted frame reports, with its own snapshot.
        mute_8 = 8'h00;
        lrclk_8 = 1'b1;
        @(negedge bclk); lrclk_8 = 1'b0;
        chk("n8_overrun_pre", int'(ovr_8), 0);
        @(negedge bclk);
        for (int k = 0; k < 8; k++) in_8[k*16 +: 16] = 16'd50;
        repeat (2) @(negedge bclk);
        lrclk_8 = 1'b1;
        q_8.push_back('{400, 0, cyc + 10});
        @(negedge bclk); lrclk_8 = 1'b0;
        chk("n8_overrun_set", int'(ovr_8), 1);
        repeat (14) @(negedge bclk);
        chk("n8_overrun_sticky", int'(ovr_8), 1);

        // Reset at t0+3 of a later frame.
        for (int k = 0; k < 8; k++) in_8[k*16 +: 16] = 16'hFF9C;
        lrclk_8 = 1'b1;
        @(negedge bclk); lrclk_8 = 1'b0;
        repeat (2) @(negedge bclk);
        rst_8 = 1'b1;
        @(negedge bclk);
        chk("n8_rst_out", int'(out_8), 0);
        chk("n8_rst_valid", int'(ov_8), 0);
        chk("n8_rst_busy", int'(busy_8), 0);
        chk("n8_rst_overrun", int'(ovr_8), 0);
        chk("n8_rst_clip", int'(clip_8), 0);
        rst_8 = 1'b0;
        repeat (15) @(negedge bclk);
        chk("n8_rst_out_hold", int'(out_8), 0);

        chk("a_pending", q_a.size(), 0);
        chk("w_pending", q_w.size(), 0);
        chk("n8_pending", q_8.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/mixer_n.md
Name: mixer_n

Overview:
- Parametrised N-channel, time-multiplexed weighted audio mixer: out = sat(sum over k of gain[k]*in[k]).
- Sits between the per-voice sources and the I2S transmitter. Runs on bclk, one multiply-accumulate per bclk cycle, and is triggered once per frame by the rising edge of lrclk.
- Successor to the fixed four-channel mixer. Adds a channel-count parameter, input snapshotting, a per-channel mute mask, saturating or wrapping output, a clip flag, frame-overrun detection and synchronous reset.

Parameters:
- BITSIZE, 16, sample and gain width. Samples are signed Q0.(BITSIZE-1); gains are signed Q1.(BITSIZE-2), so 1.0 = 2^(BITSIZE-2).
- NCH, 4, number of input channels. Legal range 1..62, so that NCH+2 fits within one 64-bclk frame.
- SATURATE, 1, output mode. 1 = clamp to the BITSIZE range; 0 = truncate to the low BITSIZE bits (wrap).

Ports:
- bclk  in  1  the only clock; 64 cycles per lrclk period.
- reset  in  1  synchronous, active-high.
- lrclk  in  1  frame strobe, sampled on bclk, synchronous to bclk.
- in_bus  in  NCH*BITSIZE  packed signed samples; channel k occupies bits [k*BITSIZE +: BITSIZE].
- gain_bus  in  NCH*BITSIZE  packed signed gains, packed the same way as in_bus.
- mute  in  NCH  bit k = 1 excludes channel k from the sum.
- out  out  BITSIZE  signed mixed sample, held until the next frame completes.
- out_valid  out  1  one-cycle pulse when out updates.
- clip  out  1  1 when the last completed frame was clamped or wrapped; updates together with out.
- busy  out  1  high while a frame is being accumulated.
- overrun  out  1  sticky; set when a frame start aborts an unfinished frame; cleared only by reset.

Behaviour:
- Reset (bclk edge with reset=1): out=0, out_valid=0, clip=0, busy=0, overrun=0, state=IDLE, acc=0, idx=0, lrclk_d=0. Reset overrides every other event in the same cycle, including one mid-frame.
- lrclk_d <= lrclk every cycle. Frame start = (lrclk==1 && lrclk_d==0) at posedge t0.
- States:
  - IDLE → MAC on frame start.
  - MAC → DONE after channel NCH-1.
  - DONE → IDLE.
  - A frame start in MAC or DONE restarts the frame: overrun<=1, the aborted frame produces no out_valid, and the sequence continues as for a start from IDLE.
- At t0: snapshot in_bus, gain_bus and mute into internal registers; acc<=0; idx<=0; busy<=1. Input changes after t0 do not affect the current frame.
- MAC, posedge t0+1+k for k=0..NCH-1: acc <= acc + (mute_s[k] ? 0 : (in_s[k]*gain_s[k]) >>> (BITSIZE-2)).
  - Full 2*BITSIZE signed product; the shift is arithmetic, i.e. floor.
  - acc width is BITSIZE+2+clog2(NCH). It never overflows internally.
- DONE, posedge t0+NCH+1:
  - out <= SATURATE ? clamp(acc, -2^(BITSIZE-1), 2^(BITSIZE-1)-1) : acc[BITSIZE-1:0].
  - clip <= (acc outside the BITSIZE range).
  - out_valid<=1 for this cycle only; busy<=0.
- Latency: frame-start edge to out_valid is NCH+1 cycles. busy is high from t0+1 through t0+NCH+1 inclusive.
- No frame start (lrclk held constant): out, clip and overrun hold; out_valid stays 0.
- NCH=1: one MAC cycle, then DONE.

Decomposition:
- Shared package mixer_pkg:
  - Q-format constants: GAIN_ONE = 2^(BITSIZE-2), SHIFT = BITSIZE-2.
  - Function acc_width(BITSIZE, NCH).
  - Saturate function sat_to(width).
  - State enum {IDLE, MAC, DONE}.
- One sub-module is natural: mixer_sat, combinational clamp/wrap from the acc width to BITSIZE, which also produces the clip flag. The shared I2S chain can reuse it.

Test Plan:
- Unity sum: BITSIZE=16, NCH=4, gains 0x4000, in={1000,2000,-500,1500}, mute=0 → out=4000, clip=0, out_valid exactly 5 cycles after the lrclk rising edge.
- Saturation: all in=0x7FFF, gains 0x4000, SATURATE=1 → out=32767, clip=1. Same inputs with all in=0x8000 → out=-32768, clip=1. Same positive case with SATURATE=0 → out=low 16 bits of 131068 (0xFFFC = -4), clip=1.
- Rounding and mute: in0=-3 with gain0=0x2000 (0.5) gives floor(-1.5) = -2; in1=100 with gain1=0x4000; mute=4'b0010 → out=-2.
- Snapshot: change in_bus and gain_bus at t0+2 → out reflects the values at t0 only; the next frame reflects the new values.
- Overrun/reset: NCH=8, second lrclk rising edge at t0+4 → overrun=1, exactly one out_valid (for the restarted frame) at new_t0+9. Assert reset at t0+3 of a later frame → all outputs 0 next cycle, no out_valid, overrun cleared.
